// File: rtl/sha256_stream_feeder_if.sv
// ---------------------------------------------------------------------------
// sha256_stream_feeder_if
//
// Bundles every non-clock/non-reset signal of the SHA-256 stream feeder.
//
//   Host byte-write port : wr_en, wr_addr[5:0], wr_data[7:0]
//   Command / status     : msg_len[6:0], start, busy, done, err, err_code[1:0]
//   Hash-core stream     : core_enable, core_data[7:0], core_data_valid,
//                          core_eof, core_ready, core_hash[255:0],
//                          core_hash_valid
//   Digest output        : dout[7:0], dout_valid, dout_last, dout_ready
//
// Modports:
//   slave  - the feeder itself (consumes host/core/downstream inputs,
//            produces the core stream, digest bytes and status).
//   master - the surrounding environment (host, hash core, downstream sink).
// ---------------------------------------------------------------------------
interface sha256_stream_feeder_if;
    // Host byte writes into the message buffer
    logic         wr_en;
    logic [5:0]   wr_addr;
    logic [7:0]   wr_data;

    // Command and status
    logic [6:0]   msg_len;
    logic         start;
    logic         busy;
    logic         done;
    logic         err;
    logic [1:0]   err_code;

    // Byte stream toward the hash core and digest coming back
    logic         core_enable;
    logic [7:0]   core_data;
    logic         core_data_valid;
    logic         core_eof;
    logic         core_ready;
    logic [255:0] core_hash;
    logic         core_hash_valid;

    // Serialized digest toward downstream
    logic [7:0]   dout;
    logic         dout_valid;
    logic         dout_last;
    logic         dout_ready;

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  msg_len, start,
        output busy, done, err, err_code,
        output core_enable, core_data, core_data_valid, core_eof,
        input  core_ready, core_hash, core_hash_valid,
        output dout, dout_valid, dout_last,
        input  dout_ready
    );

    modport master (
        output wr_en, wr_addr, wr_data,
        output msg_len, start,
        input  busy, done, err, err_code,
        input  core_enable, core_data, core_data_valid, core_eof,
        output core_ready, core_hash, core_hash_valid,
        input  dout, dout_valid, dout_last,
        output dout_ready
    );
endinterface

// File: rtl/sha256_stream_feeder.sv
// ---------------------------------------------------------------------------
// sha256_stream_feeder
//
// Buffers a short message written byte-by-byte by a host, streams it into a
// SHA-256 core (preceded by a throw-away wake byte and followed by an EOF
// marker), waits for the digest and serializes it MSB-first as 32 bytes on a
// valid/ready output.
//
// Parameters:
//   MAX_BYTES - message buffer depth in bytes (at most 64, the wr_addr range)
//   TIMEOUT   - cycles allowed in WAIT_HASH before a timeout error (<= 65535)
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - sha256_stream_feeder_if.slave, see the interface for the list
//
// Error codes on err_code (valid only while err pulses):
//   2'b01 - requested length larger than MAX_BYTES
//   2'b10 - no digest within TIMEOUT cycles
// ---------------------------------------------------------------------------
module sha256_stream_feeder #(
    parameter int MAX_BYTES = 64,
    parameter int TIMEOUT   = 20000
) (
    input  logic                   clk,
    input  logic                   rst,
    sha256_stream_feeder_if.slave  bus
);

    localparam logic [1:0]  ERR_LEN      = 2'b01;
    localparam logic [1:0]  ERR_TIMEOUT  = 2'b10;
    localparam logic [6:0]  LEN_MAX      = 7'(MAX_BYTES);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    localparam logic [6:0]  LAST_BYTE    = 7'd31;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        WAKE,
        SEND,
        EOF,
        WAIT_HASH,
        EMIT
    } state_t;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t        state_q,    state_d;
    logic [6:0]    len_q,      len_d;
    logic [6:0]    idx_q,      idx_d;      // byte index for SEND and EMIT
    logic [15:0]   timer_q,    timer_d;    // cycles spent in WAIT_HASH
    logic [255:0]  hash_q,     hash_d;
    logic          done_q,     done_d;
    logic          err_q,      err_d;
    logic [1:0]    err_code_q, err_code_d;

    // -----------------------------------------------------------------------
    // Message buffer: block RAM with a registered read port. Because the
    // read data lags the address by one cycle, the address is always one
    // byte ahead of what SEND is currently driving (byte 0 is fetched while
    // in WAKE). Contents survive reset on purpose.
    // -----------------------------------------------------------------------
    logic [7:0]    mem [MAX_BYTES];
    logic [7:0]    rd_data_q;
    logic [5:0]    rd_addr;
    logic          mem_we;

    assign mem_we = bus.wr_en && (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    // -----------------------------------------------------------------------
    // Digest byte view: byte 0 is the most significant byte of the hash.
    // -----------------------------------------------------------------------
    logic [7:0]    hash_byte [32];

    for (genvar gi = 0; gi < 32; gi++) begin : g_hash_bytes
        assign hash_byte[gi] = hash_q[255 - 8*gi -: 8];
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        hash_d     = hash_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = 2'b00;
        rd_addr    = 6'd0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.msg_len > LEN_MAX) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_LEN;
                    end else begin
                        len_d   = bus.msg_len;
                        state_d = WAIT_RDY;
                    end
                end
            end

            WAIT_RDY: begin
                if (bus.core_ready) begin
                    state_d = WAKE;
                end
            end

            WAKE: begin
                // Prefetch byte 0 so it is on rd_data_q in the first SEND cycle.
                rd_addr = 6'd0;
                idx_d   = 7'd0;
                state_d = (len_q == 7'd0) ? EOF : SEND;
            end

            SEND: begin
                // Fetch the following byte; past the end the value is unused.
                rd_addr = idx_q[5:0] + 6'd1;
                if (idx_q == len_q - 7'd1) begin
                    state_d = EOF;
                end else begin
                    idx_d = idx_q + 7'd1;
                end
            end

            EOF: begin
                timer_d = 16'd0;
                state_d = WAIT_HASH;
            end

            WAIT_HASH: begin
                // A digest arriving on the final allowed cycle still wins.
                if (bus.core_hash_valid) begin
                    hash_d  = bus.core_hash;
                    idx_d   = 7'd0;
                    state_d = EMIT;
                end else if (timer_q == TIMEOUT_LAST) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            EMIT: begin
                // dout_valid is always high here, so ready alone means accepted.
                if (bus.dout_ready) begin
                    if (idx_q == LAST_BYTE) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 7'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= 7'd0;
            idx_q      <= 7'd0;
            timer_q    <= 16'd0;
            hash_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            hash_q     <= hash_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs, decoded from the registered state so reset forces them low.
    // -----------------------------------------------------------------------
    logic in_send;
    logic in_emit;

    assign in_send = (state_q == SEND);
    assign in_emit = (state_q == EMIT);

    assign bus.busy            = (state_q != IDLE);
    assign bus.core_enable     = (state_q == WAKE) || in_send ||
                                 (state_q == EOF)  || (state_q == WAIT_HASH);
    assign bus.core_data_valid = (state_q == WAKE) || in_send;
    assign bus.core_data       = in_send ? rd_data_q : 8'h00;
    assign bus.core_eof        = (state_q == EOF);

    assign bus.dout_valid      = in_emit;
    assign bus.dout            = in_emit ? hash_byte[idx_q[4:0]] : 8'h00;
    assign bus.dout_last       = in_emit && (idx_q == LAST_BYTE);

    assign bus.done            = done_q;
    assign bus.err             = err_q;
    assign bus.err_code        = err_code_q;

endmodule

// File: doc/sha256_stream_feeder.md
SHA256_STREAM_FEEDER -- requirements
Module: sha256_stream_feeder

Interface
REQ-001 The block SHALL have parameter MAX_BYTES, default 64, giving the local message buffer depth in bytes.
REQ-002 The block SHALL have parameter TIMEOUT, default 20000, giving the maximum cycles spent waiting for a digest.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 wr_en / wr_addr / wr_data  input  1/6/8  host byte write into message buffer.
REQ-007 msg_len  input  7  message length in bytes, sampled at start.
REQ-008 start  input  1  one-cycle request to hash the buffered message.
REQ-009 busy  output  1  high from accepted start until return to IDLE.
REQ-010 core_enable / core_data / core_data_valid / core_eof  output  1/8/1/1  byte-stream drive toward the hash core.
REQ-011 core_ready  input  1  hash core idle and able to accept a message.
REQ-012 core_hash / core_hash_valid  input  256/1  digest from core; valid is a one-cycle pulse.
REQ-013 dout / dout_valid / dout_last  output  8/1/1  serialized digest bytes.
REQ-014 dout_ready  input  1  downstream accepts dout.
REQ-015 done  output  1  one-cycle pulse after the last digest byte is accepted.
REQ-016 err / err_code  output  1/2  one-cycle error pulse; code 01 = bad length, 10 = timeout.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT_RDY, WAKE, SEND, EOF, WAIT_HASH, EMIT.
REQ-018 In IDLE, wr_en SHALL write wr_data to buf[wr_addr]; writes in any other state SHALL be ignored.
REQ-019 In IDLE, start with msg_len<=MAX_BYTES SHALL latch msg_len, set busy and go to WAIT_RDY next cycle.
REQ-020 In IDLE, start with msg_len>MAX_BYTES SHALL pulse err with err_code=01, stay in IDLE, and leave busy low.
REQ-021 start outside IDLE SHALL be ignored.
REQ-022 core_enable SHALL be high in every state from WAKE through WAIT_HASH inclusive, and low elsewhere.
REQ-023 WAIT_RDY SHALL hold until core_ready=1, then enter WAKE.
REQ-024 WAKE SHALL last exactly one cycle with core_data_valid=1 and core_data=8'h00; this wake byte is discarded by the core and is not counted.
REQ-025 SEND SHALL drive buf[0..len-1] in order, one byte per cycle, with core_data_valid=1 continuously and no gaps.
REQ-026 When len=0, SEND SHALL be skipped and WAKE SHALL go directly to EOF.
REQ-027 EOF SHALL last one cycle with core_eof=1 and core_data_valid=0.
REQ-028 WAIT_HASH SHALL capture core_hash on the core_hash_valid pulse and enter EMIT.
REQ-029 WAIT_HASH SHALL count cycles; on reaching TIMEOUT without a valid pulse it SHALL pulse err with err_code=10, clear busy, and return to IDLE.
REQ-030 EMIT SHALL present 32 bytes MSB-first (byte 0 = hash[255:248]) with dout_valid=1.
REQ-031 In EMIT, dout SHALL advance only when dout_valid&&dout_ready; dout SHALL stay stable while dout_ready=0.
REQ-032 dout_last SHALL be high only with byte 31.
REQ-033 Acceptance of byte 31 SHALL pulse done on the next cycle, clear busy, and return to IDLE.
REQ-034 core_hash_valid outside WAIT_HASH SHALL be ignored.
REQ-035 The byte index counter SHALL be 7 bits and the timeout counter SHALL be 16 bits; neither SHALL wrap within a transaction.

Reset
REQ-036 With rst high at a clock edge, the block SHALL enter IDLE and drive busy, core_enable, core_data_valid, core_eof, dout_valid, dout_last, done and err to 0, and core_data, dout and err_code to 0.
REQ-037 The buffer contents SHALL NOT be cleared by reset.
REQ-038 Reset mid-transaction SHALL abort the transaction immediately, with no done or err pulse.

Verification
REQ-039 Load "abc" (61 62 63), len=3, start, with the core model attached -> WAKE, 3 SEND cycles, EOF; dout stream ba7816bf...f20015ad; done pulse.
REQ-040 len=0, start -> WAKE then EOF directly; dout stream e3b0c442...7852b855.
REQ-041 msg_len=65, start -> err=1 with err_code=01 for one cycle; busy stays 0; no core_enable.
REQ-042 "abc" with dout_ready toggled 1-0-0-1 -> no dropped or duplicated bytes; dout_last only on byte 31.
REQ-043 TIMEOUT=50 with the core never pulsing hash_valid -> err_code=10 exactly 50 cycles after WAIT_HASH entry; then IDLE.
REQ-044 rst asserted at digest byte 10 -> all outputs 0 next cycle; a new start then completes correctly.
